param_loader: RTL and testbench

PARAM_LOADER -- requirements
Module: param_loader

---
 rtl/param_loader_pkg.sv | 45 ++++
 rtl/param_loader_if.sv | 9 +
 rtl/param_frame_rx.sv | 103 ++++++++++
 rtl/param_loader.sv | 73 +++++++
 tb/tb_param_loader.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_loader_pkg.sv
// Shared constants for the parameter loader: frame header, parameter indices,
// Q10.21 power-on defaults and the receive FSM state encoding.
package param_loader_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  localparam logic [2:0] IDX_SIGMA = 3'd0;
  localparam logic [2:0] IDX_BETA  = 3'd1;
  localparam logic [2:0] IDX_RHO   = 3'd2;
  localparam logic [2:0] IDX_H     = 3'd3;
  localparam logic [2:0] IDX_X0    = 3'd4;
  localparam logic [2:0] IDX_Y0    = 3'd5;
  localparam logic [2:0] IDX_Z0    = 3'd6;
  localparam logic [2:0] IDX_START = 3'd7;

  localparam logic [31:0] DEF_SIGMA = 32'h0140_0000;  // 10.0
  localparam logic [31:0] DEF_BETA  = 32'h0055_5555;  // 2.66667
  localparam logic [31:0] DEF_RHO   = 32'h0380_0000;  // 28.0
  localparam logic [31:0] DEF_H     = 32'h0000_28F5;  // 0.005
  localparam logic [31:0] DEF_X0    = 32'h0020_0000;  // 1.0
  localparam logic [31:0] DEF_Y0    = 32'h0000_0000;  // 0.0
  localparam logic [31:0] DEF_Z0    = 32'h0020_0000;  // 1.0

  typedef enum logic [2:0] {
    IDLE,
    INDEX,
    DATA,
    CHECK,
    COMMIT
  } rx_state_e;

  function automatic logic [31:0] default_value(input logic [2:0] idx);
    case (idx)
      IDX_SIGMA: return DEF_SIGMA;
      IDX_BETA:  return DEF_BETA;
      IDX_RHO:   return DEF_RHO;
      IDX_H:     return DEF_H;
      IDX_X0:    return DEF_X0;
      IDX_Y0:    return DEF_Y0;
      IDX_Z0:    return DEF_Z0;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/param_loader_if.sv
// Byte-stream handshake between the serial receiver (master) and the loader (slave).
interface param_loader_if;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_ready_o;

  modport master (output byte_i, output byte_valid_i, input byte_ready_o);
  modport slave  (input byte_i, input byte_valid_i, output byte_ready_o);
endinterface

// File: rtl/param_frame_rx.sv
// Frame receiver: header/index/data/checksum FSM with staging register.
// Checksum verification is built only when PARAM_LOADER_CHECKSUM_EN is defined.
module param_frame_rx
  import param_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  param_loader_if.slave    bus,
  output logic             commit,
  output logic [2:0]       commit_idx,
  output logic [WIDTH-1:0] commit_data,
  output logic             frame_err
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(NBYTES) + 1;

  rx_state_e        state;
  logic             ready;
  logic [2:0]       idx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] staging;
  logic [WIDTH-1:0] shifted;
  logic             fire;
  logic             idx_ok;
  logic             last_data;
`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign bus.byte_ready_o = ready;

  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    fire       = bus.byte_valid_i && ready;
    shifted    = (staging << 8) | WIDTH'(bus.byte_i);
    idx_ok     = bus.byte_i <= 8'(IDX_START);
    last_data  = (state == DATA) && fire && (cnt == CW'(NBYTES - 1));
    commit_idx = (state == INDEX) ? bus.byte_i[2:0] : idx;
`ifdef PARAM_LOADER_CHECKSUM_EN
    commit      = (state == CHECK) && fire && (bus.byte_i == csum);
    commit_data = staging;
    frame_err   = fire && (((state == INDEX) && !idx_ok) ||
                           ((state == CHECK) && (bus.byte_i != csum)));
`else
    // Without a checksum byte the check always passes, so the frame commits
    // on its final byte and keeps the one-cycle update latency.
    commit      = last_data ||
                  ((state == INDEX) && fire && (bus.byte_i == 8'(IDX_START)));
    commit_data = shifted;
    frame_err   = (state == INDEX) && fire && !idx_ok;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the later commit override relies on last-NBA-wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready   <= 1'b1;
      idx     <= '0;
      cnt     <= '0;
      staging <= '0;
`ifdef PARAM_LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      ready <= 1'b1;
      case (state)
        IDLE: if (fire && bus.byte_i == HDR_BYTE) state <= INDEX;
        INDEX: if (fire) begin
          idx <= bus.byte_i[2:0];
          cnt <= '0;
`ifdef PARAM_LOADER_CHECKSUM_EN
          csum <= bus.byte_i;
`endif
          if (bus.byte_i < 8'(IDX_START))       state <= DATA;
          else if (bus.byte_i == 8'(IDX_START)) state <= CHECK;
          else                                  state <= IDLE;
        end
        DATA: if (fire) begin
          staging <= shifted;
          cnt     <= cnt + 1'b1;
`ifdef PARAM_LOADER_CHECKSUM_EN
          csum    <= csum ^ bus.byte_i;
`endif
          if (last_data) state <= CHECK;
        end
        CHECK:   if (fire) state <= IDLE;
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
      // A passing frame overrides whatever transition the case chose.
      if (commit) begin
        state <= COMMIT;
        ready <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_loader.sv
// Parameter loader top: seven live Q10.21 registers written by framed bytes.
// Optional checksum verification: define PARAM_LOADER_CHECKSUM_EN.
module param_loader
  import param_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  param_loader_if.slave    bus,
  output logic [WIDTH-1:0] sigma_o,
  output logic [WIDTH-1:0] beta_o,
  output logic [WIDTH-1:0] rho_o,
  output logic [WIDTH-1:0] h_o,
  output logic [WIDTH-1:0] x0_o,
  output logic [WIDTH-1:0] y0_o,
  output logic [WIDTH-1:0] z0_o,
  output logic             update_o,
  output logic             start_o,
  output logic             err_o
);

  logic             commit;
  logic             frame_err;
  logic [2:0]       commit_idx;
  logic [WIDTH-1:0] commit_data;
  logic [WIDTH-1:0] regs [7];

  param_frame_rx #(.WIDTH(WIDTH)) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .frame_err   (frame_err)
  );

  // NOTE: the parameter array is a handful of flops with distinct power-on
  // values, so it is reset element by element rather than left to RAM inference.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 7; i++) regs[i] <= WIDTH'(default_value(3'(i)));
      update_o <= 1'b0;
      start_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      update_o <= 1'b0;
      start_o  <= 1'b0;
      if (commit) begin
        err_o <= 1'b0;
        if (commit_idx == IDX_START) begin
          start_o <= 1'b1;
        end else begin
          for (int i = 0; i < 7; i++)
            if (commit_idx == 3'(i)) regs[i] <= commit_data;
          update_o <= 1'b1;
        end
      end else if (frame_err) begin
        err_o <= 1'b1;
      end
    end
  end

  assign sigma_o = regs[IDX_SIGMA];
  assign beta_o  = regs[IDX_BETA];
  assign rho_o   = regs[IDX_RHO];
  assign h_o     = regs[IDX_H];
  assign x0_o    = regs[IDX_X0];
  assign y0_o    = regs[IDX_Y0];
  assign z0_o    = regs[IDX_Z0];

endmodule

// File: tb/tb_param_loader.sv
// Self-checking bench for param_loader: directed table, hand-written corner
// sequences and random frames checked against a frame-level reference model.
module tb_param_loader;

  localparam int WIDTH = 32;
  localparam int NB    = WIDTH / 8;
`ifdef PARAM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam logic [31:0] DEF [7] = '{32'h01400000, 32'h00555555, 32'h03800000,
                                      32'h000028F5, 32'h00200000, 32'h00000000,
                                      32'h00200000};

  logic clk_i = 1'b0;
  logic rst_i;
  param_loader_if bus ();
  logic [WIDTH-1:0] sigma_o, beta_o, rho_o, h_o, x0_o, y0_o, z0_o;
  logic update_o, start_o, err_o;

  param_loader #(.WIDTH(WIDTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus      (bus),
    .sigma_o  (sigma_o),
    .beta_o   (beta_o),
    .rho_o    (rho_o),
    .h_o      (h_o),
    .x0_o     (x0_o),
    .y0_o     (y0_o),
    .z0_o     (z0_o),
    .update_o (update_o),
    .start_o  (start_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;
  int start_cnt = 0;

  logic [WIDTH-1:0] m_reg [7];
  bit               m_err;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (update_o) upd_cnt++;
      if (start_o)  start_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] get_reg(input int i);
    case (i)
      0: return sigma_o;
      1: return beta_o;
      2: return rho_o;
      3: return h_o;
      4: return x0_o;
      5: return y0_o;
      default: return z0_o;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) m_reg[i] = WIDTH'(DEF[i]);
    m_err = 1'b0;
  endfunction

  // Frame-level effect: what a whole frame does to the parameter set.
  task automatic model_frame(input int idx, input logic [WIDTH-1:0] data, input bit bad_chk,
                             output int eu, output int es);
    eu = 0;
    es = 0;
    if (idx > 7 || (CHK_EN && bad_chk)) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      if (idx == 7) es = 1;
      else begin
        m_reg[idx] = data;
        eu = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s reg%0d", tag, i), 64'(get_reg(i)), 64'(m_reg[i]));
    check({tag, " err"}, 64'(err_o), 64'(m_err));
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      @(negedge clk_i);
      bus.byte_valid_i = 1'b0;
      bus.byte_i       = 8'($urandom);
    end
    @(negedge clk_i);
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (bus.byte_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL put_byte timeout: ready stayed %b, expected 1", bus.byte_ready_o);
    end else begin
      @(posedge clk_i);
    end
    #1 bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int idx, input logic [WIDTH-1:0] data, input bit bad_chk,
                            input int gmin, input int gmax);
    logic [7:0] q[$];
    logic [7:0] chk;
    logic [7:0] b;
    q.push_back(8'hA5);
    q.push_back(8'(idx));
    chk = 8'(idx);
    if (idx < 7)
      for (int i = NB - 1; i >= 0; i--) begin
        b = data[i*8 +: 8];
        q.push_back(b);
        chk ^= b;
      end
    if (CHK_EN && idx <= 7) q.push_back(bad_chk ? (chk ^ 8'h5A) : chk);
    foreach (q[i]) put_byte(q[i], $urandom_range(gmax, gmin));
  endtask

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
    bit               exp_err;
    int               exp_upd;
    int               exp_start;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int eu, es, idx, r;
    logic [WIDTH-1:0] data;
    logic [7:0] nb;
    bit bad;

    vecs = '{
      '{0,   32'h0140_0001, 1'b0, 1, 0},
      '{8,   32'h0,         1'b1, 0, 0},
      '{1,   32'h0055_5556, 1'b0, 1, 0},
      '{255, 32'h0,         1'b1, 0, 0},
      '{7,   32'h0,         1'b0, 0, 1},
      '{6,   32'hFFE0_0000, 1'b0, 1, 0},
      '{4,   32'h7FFF_FFFF, 1'b0, 1, 0},
      '{5,   32'h8000_0000, 1'b0, 1, 0},
      '{3,   32'h0000_0000, 1'b0, 1, 0}
    };

    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;
    rst_i            = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_all("reset");
    check("reset update", 64'(update_o), 64'd0);
    check("reset start", 64'(start_o), 64'd0);
    check("reset ready", 64'(bus.byte_ready_o), 64'd1);
    rst_i = 1'b0;
    @(negedge clk_i);

    // rho frame: value must appear exactly one cycle after the final byte
    upd_cnt = 0; start_cnt = 0;
    put_byte(8'hA5, 0); put_byte(8'h02, 0); put_byte(8'h01, 0);
    put_byte(8'hE0, 0); put_byte(8'h00, 0);
    check("rho partial", 64'(rho_o), 64'h0380_0000);
    if (CHK_EN) begin
      put_byte(8'h00, 0);
      check("rho partial2", 64'(rho_o), 64'h0380_0000);
      put_byte(8'hE3, 0);
    end else begin
      put_byte(8'h00, 0);
    end
    @(negedge clk_i);
    check("rho latency", 64'(rho_o), 64'h01E0_0000);
    check("rho update pulse", 64'(update_o), 64'd1);
    check("commit ready low", 64'(bus.byte_ready_o), 64'd0);
    @(negedge clk_i);
    check("rho update cleared", 64'(update_o), 64'd0);
    check("ready back", 64'(bus.byte_ready_o), 64'd1);
    m_reg[2] = 32'h01E0_0000;
    check_all("rho");
    check("rho update count", 64'(upd_cnt), 64'd1);

    // start command
    upd_cnt = 0; start_cnt = 0;
    put_byte(8'hA5, 0); put_byte(8'h07, 0);
    if (CHK_EN) put_byte(8'h07, 0);
    @(negedge clk_i);
    check("start pulse", 64'(start_o), 64'd1);
    repeat (2) @(negedge clk_i);
    check("start count", 64'(start_cnt), 64'd1);
    check("start no update", 64'(upd_cnt), 64'd0);
    check_all("start");

    // table-driven frames
    foreach (vecs[v]) begin
      upd_cnt = 0; start_cnt = 0;
      send_frame(vecs[v].idx, vecs[v].data, 1'b0, 0, 1);
      model_frame(vecs[v].idx, vecs[v].data, 1'b0, eu, es);
      repeat (2) @(negedge clk_i);
      check($sformatf("vec%0d err", v), 64'(err_o), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d updates", v), 64'(upd_cnt), 64'(vecs[v].exp_upd));
      check($sformatf("vec%0d starts", v), 64'(start_cnt), 64'(vecs[v].exp_start));
      if (vecs[v].idx < 7)
        check($sformatf("vec%0d value", v), 64'(get_reg(vecs[v].idx)), 64'(vecs[v].data));
      check_all($sformatf("vec%0d", v));
    end

    // rejected sigma frame leaves sigma alone and sets err; a good frame clears it
    upd_cnt = 0;
    data = sigma_o;
    if (CHK_EN) begin
      put_byte(8'hA5, 0); put_byte(8'h00, 0); put_byte(8'h02, 0);
      put_byte(8'h80, 0); put_byte(8'h00, 0); put_byte(8'h00, 0);
      put_byte(8'hFF, 0);
    end else begin
      put_byte(8'hA5, 0); put_byte(8'h08, 0);
    end
    repeat (2) @(negedge clk_i);
    check("bad frame sigma", 64'(sigma_o), 64'(data));
    check("bad frame err", 64'(err_o), 64'd1);
    check("bad frame no update", 64'(upd_cnt), 64'd0);
    m_err = 1'b1;
    send_frame(1, 32'h0060_0000, 1'b0, 0, 0);
    model_frame(1, 32'h0060_0000, 1'b0, eu, es);
    repeat (2) @(negedge clk_i);
    check("err cleared", 64'(err_o), 64'd0);
    check_all("after bad");

    // noise bytes, then a frame with valid toggled every other cycle
    upd_cnt = 0;
    put_byte(8'h11, 1); put_byte(8'h22, 1);
    send_frame(2, 32'h0123_4567, 1'b0, 1, 1);
    model_frame(2, 32'h0123_4567, 1'b0, eu, es);
    repeat (2) @(negedge clk_i);
    check("noise update count", 64'(upd_cnt), 64'd1);
    check_all("noise");

    // reset in the middle of a frame after three data bytes
    put_byte(8'hA5, 0); put_byte(8'h00, 0);
    put_byte(8'h11, 0); put_byte(8'h22, 0); put_byte(8'h33, 0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    check_all("midreset");
    check("midreset ready", 64'(bus.byte_ready_o), 64'd1);
    rst_i = 1'b0;
    upd_cnt = 0;
    put_byte(8'h44, 0);
    if (CHK_EN) put_byte(8'hAA, 0);
    repeat (2) @(negedge clk_i);
    check("midreset no commit", 64'(upd_cnt), 64'd0);
    check_all("midreset tail");
    send_frame(0, 32'h0280_0000, 1'b0, 0, 0);
    model_frame(0, 32'h0280_0000, 1'b0, eu, es);
    repeat (2) @(negedge clk_i);
    check("midreset frame", 64'(sigma_o), 64'h0280_0000);
    check_all("post reset");

    // random frames against the frame-level model
    for (int n = 0; n < 60; n++) begin
      upd_cnt = 0; start_cnt = 0;
      repeat ($urandom_range(2, 0)) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h3C;
        put_byte(nb, $urandom_range(2, 0));
      end
      r = $urandom_range(9, 0);
      if (r == 9)      idx = $urandom_range(255, 8);
      else if (r == 8) idx = 7;
      else             idx = r;
      data = WIDTH'($urandom);
      bad  = CHK_EN && ($urandom_range(4, 0) == 0);
      send_frame(idx, data, bad, 0, 2);
      model_frame(idx, data, bad, eu, es);
      repeat (2) @(negedge clk_i);
      check($sformatf("rand%0d updates", n), 64'(upd_cnt), 64'(eu));
      check($sformatf("rand%0d starts", n), 64'(start_cnt), 64'(es));
      check_all($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
